// File: rtl/vga_output_stage.sv
// rtl/vga_output_stage.sv - VGA raster counters, sync re-timing and DAC output register
// Sync/blank are delayed to meet the drawer's colour, then all pins are registered together.
module vga_output_stage #(
   parameter int unsigned H_TOTAL    = 800,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 144,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_TOTAL    = 525,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 35,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [23:0] rgb_color,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic        sync_n,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        frame_start
);

   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0]  V_SYNC_W = 10'(V_SYNC);
   localparam logic [10:0] H_ACT_LO = 11'(H_BACK);
   localparam logic [10:0] H_ACT_HI = 11'(H_BACK + H_ACTIVE);
   localparam logic [10:0] V_ACT_LO = 11'(V_BACK);
   localparam logic [10:0] V_ACT_HI = 11'(V_BACK + V_ACTIVE);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       h_wrap;
   logic       frame_end;

   logic       hs_raw, vs_raw, act_raw;

   logic [PIPE_DELAY-1:0] hs_dly_q, hs_dly_d;
   logic [PIPE_DELAY-1:0] vs_dly_q, vs_dly_d;
   logic [PIPE_DELAY-1:0] act_dly_q, act_dly_d;

   logic        hsync_q, vsync_q, blank_n_q, frame_start_q;
   logic [23:0] rgb_q, rgb_d;

   always_comb begin
      h_wrap    = (h_cnt_q == H_LAST);
      frame_end = h_wrap && (v_cnt_q == V_LAST);
      h_cnt_d   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d   = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end
   end

   // Active window compared in 11 bits so a window ending at 1024 still decodes.
   always_comb begin
      hs_raw  = !(h_cnt_q < H_SYNC_W);
      vs_raw  = !(v_cnt_q < V_SYNC_W);
      act_raw = ({1'b0, h_cnt_q} >= H_ACT_LO) && ({1'b0, h_cnt_q} < H_ACT_HI) &&
                ({1'b0, v_cnt_q} >= V_ACT_LO) && ({1'b0, v_cnt_q} < V_ACT_HI);
   end

   always_comb begin
      hs_dly_d     = hs_dly_q;
      vs_dly_d     = vs_dly_q;
      act_dly_d    = act_dly_q;
      hs_dly_d[0]  = hs_raw;
      vs_dly_d[0]  = vs_raw;
      act_dly_d[0] = act_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
         hs_dly_d[i]  = hs_dly_q[i-1];
         vs_dly_d[i]  = vs_dly_q[i-1];
         act_dly_d[i] = act_dly_q[i-1];
      end
   end

   always_comb begin
      rgb_d = act_dly_q[PIPE_DELAY-1] ? rgb_color : 24'h000000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         hs_dly_q      <= '1;
         vs_dly_q      <= '1;
         act_dly_q     <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_n_q     <= 1'b0;
         rgb_q         <= 24'h000000;
         frame_start_q <= 1'b0;
      end else if (pix_en) begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hs_dly_q      <= hs_dly_d;
         vs_dly_q      <= vs_dly_d;
         act_dly_q     <= act_dly_d;
         hsync_q       <= hs_dly_q[PIPE_DELAY-1];
         vsync_q       <= vs_dly_q[PIPE_DELAY-1];
         blank_n_q     <= act_dly_q[PIPE_DELAY-1];
         rgb_q         <= rgb_d;
         frame_start_q <= frame_end;
      end
   end

   assign x           = h_cnt_q;
   assign y           = v_cnt_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_n_q;
   assign sync_n      = 1'b0;
   assign red         = rgb_q[23:16];
   assign green       = rgb_q[15:8];
   assign blue        = rgb_q[7:0];
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// tb/tb_vga_output_stage.sv - scoreboard bench for vga_output_stage on a reduced raster
module tb_vga_output_stage;

   localparam int HT = 100, HS = 12, HB = 20, HA = 64;
   localparam int VT = 20,  VS = 2,  VB = 4,  VA = 12;
   localparam int PD = 2;
   localparam logic [26:0] RST_PINS = {1'b1, 1'b1, 1'b0, 24'h000000};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b0;
   logic [23:0] rgb_color = 24'h0;
   logic [9:0]  x, y;
   logic        hsync, vsync, blank_n, sync_n, frame_start;
   logic [7:0]  red, green, blue;

   always #5 clk = ~clk;

   vga_output_stage #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
      .PIPE_DELAY(PD)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .rgb_color(rgb_color),
      .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
      .sync_n(sync_n), .red(red), .green(green), .blue(blue),
      .frame_start(frame_start)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   int          mh, mv;
   logic        fs_m;
   int          hist_h[$], hist_v[$];
   logic [26:0] exp_q[$];
   logic [26:0] cur_pins;
   logic        align = 1'b0;

   int   hs_period, hs_low, h_falls, vs_period, vs_low, v_falls, fs_period;
   logic hs_prev, vs_prev, blk_prev, align_done;
   logic [23:0] prev_rgb;

   function automatic logic [26:0] decode(input int h, input int v, input logic [23:0] c);
      logic hs, vs, act;
      hs  = !(h < HS);
      vs  = !(v < VS);
      act = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
      return {hs, vs, act, act ? c : 24'h000000};
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; fs_m = 1'b0;
      hist_h.delete(); hist_v.delete(); exp_q.delete();
      cur_pins = RST_PINS;
      hs_period = 0; hs_low = 0; h_falls = 0; hs_prev = 1'b1;
      vs_period = 0; vs_low = 0; v_falls = 0; vs_prev = 1'b1;
      fs_period = 0; blk_prev = 1'b0; prev_rgb = 24'h0;
   endtask

   task automatic check_pins(input string tag);
      chk({tag, "_pins"}, {5'b0, hsync, vsync, blank_n, red, green, blue}, {5'b0, cur_pins});
      chk({tag, "_xy"}, {12'b0, x, y}, {12'b0, 10'(mh), 10'(mv)});
      chk({tag, "_fs"}, {31'b0, frame_start}, {31'b0, fs_m});
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b0; pix_en = 1'b0; rgb_color = 24'hFFFFFF;
      #1;
      model_reset();
      check_pins("rst_async");
      repeat (n) @(negedge clk);
      check_pins("rst_hold");
      chk("sync_n", {31'b0, sync_n}, 32'd0);
      reset = 1'b1;
   endtask

   task automatic monitor();
      logic [23:0] rgb_now;
      rgb_now = {red, green, blue};
      hs_period++; vs_period++; fs_period++;
      if (hs_prev && !hsync) begin
         if (h_falls > 0) chk("h_period", hs_period, HT);
         h_falls++; hs_period = 0; hs_low = 0;
      end
      if (!hsync) hs_low++;
      if (!hs_prev && hsync && h_falls > 0) chk("h_low", hs_low, HS);
      hs_prev = hsync;
      if (vs_prev && !vsync) begin
         if (v_falls > 0) chk("v_period", vs_period, HT * VT);
         v_falls++; vs_period = 0; vs_low = 0;
      end
      if (!vsync) vs_low++;
      if (!vs_prev && vsync && v_falls > 0) chk("v_low", vs_low, VS * HT);
      vs_prev = vsync;
      if (frame_start) begin
         chk("fs_period", fs_period, HT * VT);
         chk("fs_origin", {12'b0, x, y}, 32'd0);
         fs_period = 0;
      end
      if (align) begin
         if (blank_n && !blk_prev && !align_done) begin
            chk("first_act", {8'b0, rgb_now}, {8'b0, 8'(HB >> 8), 8'(HB), 8'(VB)});
            align_done = 1'b1;
         end
         if (!blank_n && blk_prev) begin
            chk("last_act", {16'b0, prev_rgb[23:8]}, {16'b0, 16'(HB + HA - 1)});
            chk("post_act", {8'b0, rgb_now}, 32'd0);
         end
      end
      blk_prev = blank_n;
      prev_rgb = rgb_now;
   endtask

   task automatic step(input logic en);
      int ph, pv;
      @(negedge clk);
      pix_en = en;
      rgb_color = 24'($urandom);
      if (en) begin
         hist_h.push_back(mh);
         hist_v.push_back(mv);
         if (hist_h.size() > PD) begin
            ph = hist_h.pop_front();
            pv = hist_v.pop_front();
            if (align) rgb_color = {6'b0, 10'(ph), 8'(pv)};
            exp_q.push_back(decode(ph, pv, rgb_color));
         end else begin
            exp_q.push_back(RST_PINS);
         end
         fs_m = (mh == HT - 1) && (mv == VT - 1);
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
      @(posedge clk);
      #1;
      if (en) cur_pins = exp_q.pop_front();
      check_pins("run");
      if (en) monitor();
   endtask

   initial begin
      align_done = 1'b0;
      model_reset();
      do_reset(5);

      align = 1'b1;
      for (int i = 0; i < 5000; i++) step(1'b1);
      align = 1'b0;

      for (int i = 0; i < 8000; i++) step(i[0] ? 1'b0 : 1'b1);

      for (int i = 0; i < 2000; i++) step(($urandom % 3) != 0);

      for (int i = 0; i < 3 * HT * VT && !(mh == 40 && mv == 10); i++) step(1'b1);
      chk("mid_pos", {12'b0, 10'(mh), 10'(mv)}, {12'b0, 10'd40, 10'd10});
      do_reset(1);
      for (int i = 0; i < 2500; i++) step(1'b1);

      chk("align_seen", {31'b0, align_done}, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
